// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester and SRAM-controller handshake bundle for sram_arbiter.
//   V port : v_req_in, v_addr_in -> v_ack_out, v_valid_out, v_data_out (read-only)
//   H port : h_req_in, h_rw_in, h_addr_in, h_wdata_in -> h_ack_out, h_valid_out, h_rdata_out
//   Ctrl   : trig_out, rw_out, addr_out, w_data_out -> controller; r_data_in, done_in <- controller
// Modports: slave = the arbiter's view, master = the requesters/controller side.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 8
) ();
  logic              v_req_in;
  logic [ADDR_W-1:0] v_addr_in;
  logic              v_ack_out;
  logic              v_valid_out;
  logic [DATA_W-1:0] v_data_out;

  logic              h_req_in;
  logic              h_rw_in;
  logic [ADDR_W-1:0] h_addr_in;
  logic [DATA_W-1:0] h_wdata_in;
  logic              h_ack_out;
  logic              h_valid_out;
  logic [DATA_W-1:0] h_rdata_out;

  logic              trig_out;
  logic              rw_out;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] w_data_out;
  logic [DATA_W-1:0] r_data_in;
  logic              done_in;

  modport slave (
    input  v_req_in, v_addr_in, h_req_in, h_rw_in, h_addr_in, h_wdata_in,
           r_data_in, done_in,
    output v_ack_out, v_valid_out, v_data_out, h_ack_out, h_valid_out, h_rdata_out,
           trig_out, rw_out, addr_out, w_data_out
  );

  modport master (
    output v_req_in, v_addr_in, h_req_in, h_rw_in, h_addr_in, h_wdata_in,
           r_data_in, done_in,
    input  v_ack_out, v_valid_out, v_data_out, h_ack_out, h_valid_out, h_rdata_out,
           trig_out, rw_out, addr_out, w_data_out
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port (video read-only V, host read/write H) arbiter and sequencer
// in front of a single-port SRAM controller. V has fixed priority; a done timeout
// aborts a stuck access.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   bus (slave)   : V/H requester handshakes and controller trig/rw/addr/data/done
//   owner_out     : 0 = V, 1 = H (current or last owner)
//   busy_out      : high while an access is being issued or awaited
//   timeout_out   : 1-cycle pulse when done_in never arrived
// Optional build macro SRAM_ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive V grants
// with H pending, the next decision goes to H.
module sram_arbiter #(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus,
  output logic          owner_out,
  output logic          busy_out,
  output logic          timeout_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam int unsigned TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] to_cnt;
  logic          any_req;
  logic          pick_h;

  assign any_req = bus.v_req_in | bus.h_req_in;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;

  always_comb begin
    pick_h = !bus.v_req_in || (bus.h_req_in && (starve_cnt == STARVE_LIM));
  end

  // Counts V grants made while H waits; any H grant or H going idle resets it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (!bus.h_req_in || pick_h) begin
        starve_cnt <= '0;
      end else begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  assign pick_h = !bus.v_req_in;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      to_cnt          <= '0;
      bus.trig_out    <= 1'b0;
      bus.rw_out      <= 1'b0;
      bus.addr_out    <= '0;
      bus.w_data_out  <= '0;
      bus.v_ack_out   <= 1'b0;
      bus.v_valid_out <= 1'b0;
      bus.v_data_out  <= '0;
      bus.h_ack_out   <= 1'b0;
      bus.h_valid_out <= 1'b0;
      bus.h_rdata_out <= '0;
      owner_out       <= 1'b0;
      busy_out        <= 1'b0;
      timeout_out     <= 1'b0;
    end else begin
      bus.trig_out    <= 1'b0;
      bus.v_ack_out   <= 1'b0;
      bus.h_ack_out   <= 1'b0;
      bus.v_valid_out <= 1'b0;
      bus.h_valid_out <= 1'b0;
      timeout_out     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (any_req) begin
            state        <= S_ISSUE;
            bus.trig_out <= 1'b1;
            busy_out     <= 1'b1;
            owner_out    <= pick_h;
            if (pick_h) begin
              bus.rw_out     <= bus.h_rw_in;
              bus.addr_out   <= bus.h_addr_in;
              bus.w_data_out <= bus.h_wdata_in;
              bus.h_ack_out  <= 1'b1;
            end else begin
              bus.rw_out     <= 1'b1;
              bus.addr_out   <= bus.v_addr_in;
              bus.w_data_out <= '0;
              bus.v_ack_out  <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          state  <= S_WAIT;
          to_cnt <= '0;
        end

        S_WAIT: begin
          // done_in is checked first so a completion on the expiry cycle wins.
          if (bus.done_in) begin
            state    <= S_IDLE;
            busy_out <= 1'b0;
            if (owner_out) begin
              if (bus.rw_out) begin
                bus.h_rdata_out <= bus.r_data_in;
              end
              bus.h_valid_out <= 1'b1;
            end else begin
              bus.v_data_out  <= bus.r_data_in;
              bus.v_valid_out <= 1'b1;
            end
          end else if (to_cnt == TO_LAST) begin
            state       <= S_IDLE;
            busy_out    <= 1'b0;
            timeout_out <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
